// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared types and constants for the nRISC multicycle control unit.
// Holds the FSM state encoding, the 3-bit opcodes, the mux-select codes and the
// control-word struct passed from the state decoder to the top.
package nrisc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    WB_ALU,
    MEM_ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    BRANCH,
    JUMP,
    HALT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_BEQZ = 3'b100;
  localparam logic [2:0] OP_JR   = 3'b101;
  localparam logic [2:0] OP_ILL  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // PC source mux
  localparam logic [1:0] PC_SRC_INC = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_REG = 2'b10;

  // ALU operand-B mux
  localparam logic [1:0] ALUB_RS   = 2'b00;
  localparam logic [1:0] ALUB_ONE  = 2'b01;
  localparam logic [1:0] ALUB_SX1  = 2'b10;
  localparam logic [1:0] ALUB_SX2  = 2'b11;

  // ALU operation
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_PASSA = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst_sel;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/controle_decod.sv
// controle_decod: combinational state-to-control-word decode (Moore outputs).
// Latency: 0 cycles (pure logic). Backpressure: mem_ready gates the FETCH
// PC/IR strobes so a stalled fetch never advances the PC.
// Ports: state (registered FSM state), zero (ALU zero flag), sub_sel (instr
// bit 0, selects SUB in EXEC_R), mem_ready (memory handshake), ctrl (outputs).
module controle_decod
  import nrisc_pkg::*;
(
  input  state_t state,
  input  logic   zero,
  input  logic   sub_sel,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.pc_src   = PC_SRC_INC;
        // PC and IR only load on the cycle the fetched word is actually there.
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      EXEC_R: begin
        ctrl.alu_src_b = ALUB_RS;
        ctrl.alu_op    = sub_sel ? ALU_SUB : ALU_ADD;
      end
      EXEC_I: begin
        ctrl.alu_src_b = ALUB_SX2;
        ctrl.alu_op    = ALU_ADD;
      end
      WB_ALU: begin
        ctrl.reg_write   = 1'b1;
        ctrl.reg_dst_sel = 1'b0;
      end
      MEM_ADDR: begin
        ctrl.alu_src_b = ALUB_SX1;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_RD: ctrl.mem_read = 1'b1;
      WB_MEM: begin
        ctrl.reg_write   = 1'b1;
        ctrl.reg_dst_sel = 1'b1;
      end
      MEM_WR: ctrl.mem_write = 1'b1;
      BRANCH: begin
        ctrl.alu_op   = ALU_PASSA;
        ctrl.pc_src   = PC_SRC_BR;
        ctrl.pc_write = zero;
      end
      JUMP: begin
        ctrl.pc_src   = PC_SRC_REG;
        ctrl.pc_write = 1'b1;
      end
      HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multicycle control FSM for the 8-bit nRISC datapath.
// Latency (FETCH included): R/ADDI 4, LW 5, SW 4, BEQZ 3, JR 3 cycles.
// Backpressure: with NRISC_MEM_WAIT_EN defined, FETCH/MEM_RD/MEM_WR hold until
// mem_ready=1 (adds the mem_ready input); otherwise memory is single-cycle.
// Ports: clk/rst_n (async active-low), instr (IR), zero (ALU flag), datapath
// selects and strobes, halted, illegal_op pulse, instr_count (retired, wraps).
module unidade_controle
  import nrisc_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero,
`ifdef NRISC_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_dst_sel,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               halted,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_count
);

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ill_q, ill_d;
  logic               retire;
  logic               mem_rdy;
  logic [2:0]         opcode;
  ctrl_t              ctrl;

`ifdef NRISC_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  assign opcode = instr[INSTR_W-1 -: 3];

  // Operand fields are consumed by the datapath, not by the controller.
  logic unused_instr;
  assign unused_instr = ^instr[INSTR_W-4:1];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ill_d   = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (mem_rdy) state_d = DECODE;
      DECODE: begin
        op_d = opcode;
        unique case (opcode)
          OP_ADD:        state_d = EXEC_R;
          OP_ADDI:       state_d = EXEC_I;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQZ:       state_d = BRANCH;
          OP_JR:         state_d = JUMP;
          OP_HALT: begin
            // HALT counts as retired on the way in; it never leaves.
            state_d = HALT;
            retire  = 1'b1;
          end
          default: begin
            state_d = FETCH;
            ill_d   = 1'b1;
          end
        endcase
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      MEM_ADDR:       state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:         if (mem_rdy) state_d = WB_MEM;
      MEM_WR: begin
        if (mem_rdy) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      WB_ALU, WB_MEM, BRANCH, JUMP: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  controle_decod u_decod (
    .state     (state_q),
    .zero      (zero),
    .sub_sel   (instr[0]),
    .mem_ready (mem_rdy),
    .ctrl      (ctrl)
  );

  assign pc_write    = ctrl.pc_write;
  assign pc_src      = ctrl.pc_src;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_op      = ctrl.alu_op;
  assign reg_dst_sel = ctrl.reg_dst_sel;
  assign ir_write    = ctrl.ir_write;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign reg_write   = ctrl.reg_write;
  assign halted      = ctrl.halted;
  assign illegal_op  = ill_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Testbench for unidade_controle: random instruction stream against an
// instruction-level reference model; expected per-cycle control words are
// queued by the stimulus and compared by an independent monitor on negedge.
module tb_unidade_controle;
  import nrisc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] instr;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, reg_dst_sel, ir_write, mem_read, mem_write, reg_write;
  logic       halted, illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [7:0] instr_count;

  always #5 clk = ~clk;

  unidade_controle #(.INSTR_W(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .zero        (zero),
`ifdef NRISC_MEM_WAIT_EN
    .mem_ready   (mem_ready),
`endif
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .reg_dst_sel (reg_dst_sel),
    .ir_write    (ir_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

`ifndef NRISC_MEM_WAIT_EN
  logic unused_mr;
  assign unused_mr = mem_ready;
`endif

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst_sel;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       halted;
    logic       illegal_op;
    logic [7:0] instr_count;
  } obs_t;

  obs_t       exp_q[$];
  string      tag_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] mcnt;
  bit         ill_pend;
  int         force_w  = -1;

  // Monitor: one expected control word per cycle once stimulus has started.
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {pc_write, pc_src, alu_src_b, alu_op, reg_dst_sel, ir_write, mem_read,
           mem_write, reg_write, halted, illegal_op, instr_count};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s cycle=%0d actual=%h expected=%h", t, cyc, a, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  function automatic obs_t mk(input logic pw, input logic [1:0] ps, input logic [1:0] asb,
                              input logic [1:0] aop, input logic rds, input logic irw,
                              input logic mrd, input logic mwr, input logic rw,
                              input logic h, input logic il);
    obs_t o;
    o = {pw, ps, asb, aop, rds, irw, mrd, mwr, rw, h, il, 8'h00};
    return o;
  endfunction

  function automatic logic rb();
    return ($urandom & 32'd1) != 0;
  endfunction

  function automatic int nwaits();
    int w;
    w = 0;
`ifdef NRISC_MEM_WAIT_EN
    if (force_w >= 0) begin
      w = force_w;
      force_w = -1;
    end else begin
      w = $urandom_range(0, 3);
    end
`endif
    return w;
  endfunction

  // One clock cycle: drive inputs, queue the expected word, advance.
  task automatic step(input obs_t e, input string t, input logic z, input logic mr, input bit ret);
    zero      = z;
    mem_ready = mr;
    e.instr_count = mcnt;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    if (ret) mcnt = mcnt + 8'd1;
  endtask

  // Reference model of one instruction, from FETCH through its last state.
  task automatic issue(input logic [7:0] iw, input int zsel);
    obs_t zr;
    int   w;
    logic z;
    zr = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    instr = iw;
    w = nwaits();
    for (int i = 0; i <= w; i++) begin
      logic last;
      last = (i == w);
      step(mk(last, 2'b00, 2'b00, 2'b00, 0, last, 1, 0, 0, 0, ill_pend && (i == 0)),
           "fetch", rb(), last, 0);
    end
    ill_pend = 0;
    step(zr, "decode", rb(), rb(), iw[7:5] == OP_HALT);
    case (iw[7:5])
      OP_ADD: begin
        step(mk(0, 2'b00, 2'b00, {1'b0, iw[0]}, 0, 0, 0, 0, 0, 0, 0), "exec_r", rb(), rb(), 0);
        step(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0), "wb_alu", rb(), rb(), 1);
      end
      OP_ADDI: begin
        step(mk(0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0), "exec_i", rb(), rb(), 0);
        step(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0), "wb_alu", rb(), rb(), 1);
      end
      OP_LW: begin
        step(mk(0, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0), "mem_addr", rb(), rb(), 0);
        w = nwaits();
        for (int i = 0; i <= w; i++)
          step(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0), "mem_rd", rb(), i == w, 0);
        step(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0), "wb_mem", rb(), rb(), 1);
      end
      OP_SW: begin
        step(mk(0, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0), "mem_addr", rb(), rb(), 0);
        w = nwaits();
        for (int i = 0; i <= w; i++)
          step(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0), "mem_wr", rb(), i == w, i == w);
      end
      OP_BEQZ: begin
        z = (zsel == 2) ? rb() : (zsel == 1);
        step(mk(z, 2'b01, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0), "branch", z, rb(), 1);
      end
      OP_JR:
        step(mk(1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0), "jump", rb(), rb(), 1);
      OP_ILL:
        ill_pend = 1;
      default:
        for (int i = 0; i < 20; i++)
          step(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0), "halt", rb(), rb(), 0);
    endcase
  endtask

  initial begin
    obs_t       zr;
    logic [2:0] op;
    zr        = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    rst_n     = 1'b0;
    instr     = 8'h00;
    zero      = 1'b0;
    mem_ready = 1'b0;
    mcnt      = 8'h00;
    ill_pend  = 0;
    @(posedge clk);
    #1;
    repeat (3) step(zr, "reset", rb(), rb(), 0);
    rst_n = 1'b1;
    step(zr, "idle", rb(), rb(), 0);

    // Directed: first fetch stalls three cycles when wait states are enabled.
    force_w = 3;
    issue(8'b000_01_10_1, 2);
    issue(8'b001_00011, 2);
    issue(8'b010_00100, 2);
    issue(8'b100_00000, 1);
    issue(8'b100_00000, 0);
    issue(8'b101_00010, 2);
    issue(8'b110_00000, 2);
    issue(8'b011_00111, 2);
    issue(8'b000_00010, 2);
    issue(8'b110_10101, 2);
    issue(8'b110_00001, 2);
    issue(8'b001_11111, 2);

    // Random mix without HALT; enough retires to wrap the 8-bit counter.
    repeat (400) begin
      op = 3'($urandom_range(0, 6));
      issue({op, 5'($urandom)}, 2);
    end

    issue(8'b111_00000, 2);

    // Reset while halted, then resume from IDLE.
    rst_n    = 1'b0;
    mcnt     = 8'h00;
    ill_pend = 0;
    repeat (2) step(zr, "reset_halt", rb(), rb(), 0);
    rst_n = 1'b1;
    step(zr, "idle2", rb(), rb(), 0);
    issue(8'b001_00001, 2);
    issue(8'b000_00001, 2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Multicycle control FSM for the 8-bit nRISC datapath.
- Sequences fetch/decode/execute/memory/write-back.
- Drives the select lines of the 4:1 ALU-B mux, the 3:1 PC-source mux and the 2:1 write-back mux, plus the PC, IR, register-file and memory strobes.
- Counts retired instructions; halts on HALT.

Parameters:
- INSTR_W, 8, instruction width; opcode is instr[INSTR_W-1 -: 3].
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  INSTR_W  IR contents; stable from the cycle after FETCH.
- zero  in  1  ALU zero flag, valid in BRANCH.
- pc_write  out  1  PC load enable.
- pc_src  out  2  3:1 mux select: 00 PC+1 (adder), 01 branch target, 10 register (JR).
- alu_src_b  out  2  4:1 mux select: 00 rs, 01 const 1, 10 sext1to8, 11 sext2to8.
- alu_op  out  2  00 add, 01 sub, 10 pass-A.
- reg_dst_sel  out  1  2:1 mux select: 0 ALU result, 1 memory data.
- ir_write, mem_read, mem_write, reg_write  out  1 each  strobes.
- halted  out  1  high in HALT.
- illegal_op  out  1  one-cycle pulse on opcode 110.
- instr_count  out  CNT_W  retired instructions; wraps to 0.

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low (clk, rst_n).
- Moore outputs, decoded from the registered state. Opcode is latched into op_q in DECODE.
- Reset values:
  - state = IDLE, op_q = 0, instr_count = 0.
  - All strobes 0, all selects 00/0, halted 0, illegal_op 0.
- Reset can assert mid-instruction. It aborts immediately with no partial memory or register write.
- IDLE: all outputs 0; goes to FETCH on the next edge.
- FETCH: mem_read=1, ir_write=1, pc_write=1, pc_src=00 (PC <= PC+1); goes to DECODE.
- DECODE: latch opcode, then branch on it:
  - 000 -> EXEC_R
  - 011 -> EXEC_I
  - 001 and 010 -> MEM_ADDR
  - 100 -> BRANCH
  - 101 -> JUMP
  - 111 -> HALT
  - 110 -> FETCH, with illegal_op=1 in the next cycle and no retire.
- EXEC_R: alu_src_b=00; alu_op = instr[0] ? 01 : 00; goes to WB_ALU.
- EXEC_I (ADDI): alu_src_b=11, alu_op=00; goes to WB_ALU.
- WB_ALU: reg_write=1, reg_dst_sel=0; retire; goes to FETCH.
- MEM_ADDR: alu_src_b=10, alu_op=00. Opcode 001 goes to MEM_RD; 010 goes to MEM_WR.
- MEM_RD: mem_read=1; goes to WB_MEM.
- WB_MEM: reg_write=1, reg_dst_sel=1; retire; goes to FETCH.
- MEM_WR: mem_write=1; retire; goes to FETCH.
- BRANCH (BEQZ): alu_op=10, pc_src=01, pc_write=zero; retire; goes to FETCH.
- JUMP (JR): pc_src=10, pc_write=1; retire; goes to FETCH.
- HALT: halted=1, all strobes 0; stays until reset. The HALT instruction retires once on entry.
- Latency in cycles, FETCH included: R/ADDI 4, LW 5, SW 4, BEQZ 3, JR 3.
- Retire: instr_count increments by 1 at the edge leaving the retiring state, modulo 2^CNT_W (255 -> 0).
- Never assert mem_read and mem_write together. Never assert reg_write outside WB_ALU/WB_MEM.

Optional Feature:
- Macro: NRISC_MEM_WAIT_EN. Adds input mem_ready (1 bit).
- With the macro: FETCH, MEM_RD and MEM_WR hold state and outputs until mem_ready=1.
  - In FETCH, pc_write and ir_write assert only in the cycle where mem_ready=1.
  - Latency grows by the number of wait cycles.
- Without the macro: no mem_ready port; memory is treated as single-cycle.

Decomposition:
- Package nrisc_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, HALT);
  - opcode constants (OP_ADD=000, OP_LW=001, OP_SW=010, OP_ADDI=011, OP_BEQZ=100, OP_JR=101, OP_ILL=110, OP_HALT=111);
  - mux-select constants for pc_src, alu_src_b and alu_op.
- One sub-module: controle_decod, a purely combinational state-to-outputs decode. The FSM register and counter stay in the top.

Test Plan:
- Hold rst_n=0 for 3 cycles, then release. All outputs 0 while low; IDLE, then FETCH one cycle after release with mem_read=ir_write=pc_write=1, pc_src=00.
- instr=8'b000_01_10_1 (SUB) -> EXEC_R shows alu_op=01; reg_write=1 exactly 4 cycles after FETCH entry; instr_count 0->1.
- instr=8'b001_xxxxx (LW) -> 5-cycle sequence; WB_MEM shows reg_dst_sel=1. instr=8'b010_xxxxx (SW) -> mem_write=1 for exactly one cycle, reg_write stays 0.
- BEQZ with zero=1 -> pc_write=1, pc_src=01 in BRANCH; with zero=0 -> pc_write=0. JR -> pc_src=10, pc_write=1.
- Opcode 110 -> illegal_op pulses once, instr_count unchanged. Opcode 111 -> halted=1 held for 20 cycles; rst_n low mid-HALT returns to IDLE. Retire 256 instructions -> instr_count wraps to 0.
- NRISC_MEM_WAIT_EN defined, mem_ready low 3 cycles in FETCH -> state held, pc_write asserts only on the mem_ready=1 cycle.
